// File: rtl/snoop_mem_param.sv
// Shared-memory controller on a snooping bus.
// Absorbs processor write-backs into local storage and answers read-misses
// in FIFO order, LATENCY edges after each request becomes the active head.
// Return messages are driven from a register, at most one per cycle.
module snoop_mem_param #(
    parameter int ID_W    = 2,
    parameter int ADDR_W  = 1,
    parameter int DATA_W  = 3,
    parameter int LATENCY = 1,
    parameter int QDEPTH  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ID_W+ADDR_W+DATA_W+3:0]   barin,
    output logic [ID_W+ADDR_W+DATA_W+3:0]   barout,
    output logic                            busy,
    output logic                            ovf
);

    localparam int BW     = 1 + ID_W + 3 + ADDR_W + DATA_W;
    localparam int PTR_W  = $clog2(QDEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int LCNT_W = $clog2(LATENCY) + 1;
    localparam int MEM_N  = 2 ** ADDR_W;

    localparam logic [2:0]        OP_RM    = 3'b001;
    localparam logic [2:0]        OP_RET   = 3'b011;
    localparam logic [2:0]        OP_WB    = 3'b100;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(QDEPTH);
    localparam logic [CNT_W-1:0]  ZERO_CNT = {CNT_W{1'b0}};
    localparam logic [LCNT_W-1:0] LAT_M1   = LCNT_W'(LATENCY - 1);
    localparam logic [LCNT_W-1:0] LCNT_ONE = LCNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_ISSUE = 2'b10
    } state_t;

    // Builds a memory-originated return message.
    function automatic logic [BW-1:0] make_return(
        input logic [ID_W-1:0]   id,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] data
    );
        return {1'b0, id, OP_RET, addr, data};
    endfunction

    // Incoming message fields
    logic              in_src_s;
    logic [ID_W-1:0]   in_id_s;
    logic [2:0]        in_op_s;
    logic [ADDR_W-1:0] in_addr_s;
    logic [DATA_W-1:0] in_data_s;
    logic              rm_s;
    logic              wb_s;

    assign in_src_s  = barin[BW-1];
    assign in_id_s   = barin[BW-2 -: ID_W];
    assign in_op_s   = barin[ADDR_W+DATA_W+2 -: 3];
    assign in_addr_s = barin[ADDR_W+DATA_W-1 -: ADDR_W];
    assign in_data_s = barin[DATA_W-1:0];
    assign rm_s      = in_src_s && (in_op_s == OP_RM);
    assign wb_s      = in_src_s && (in_op_s == OP_WB);

    // Storage and queue state
    logic [DATA_W-1:0] mem_r    [MEM_N];
    logic [ID_W-1:0]   q_id_r   [QDEPTH];
    logic [ADDR_W-1:0] q_addr_r [QDEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_nxt_s;

    // FSM state
    state_t            state_r;
    state_t            state_nxt_s;
    logic [LCNT_W-1:0] lcnt_r;
    logic [LCNT_W-1:0] lcnt_nxt_s;

    // Control
    logic              q_nonempty_s;
    logic              have_head_s;
    logic              activate_s;
    logic              issue_s;
    logic              pop_s;
    logic              bypass_s;
    logic              push_s;
    logic              drop_s;
    logic [ID_W-1:0]   head_id_s;
    logic [ADDR_W-1:0] head_addr_s;
    logic [DATA_W-1:0] ret_data_s;
    logic [BW-1:0]     barout_nxt_s;

    // Head selection: the queue head, or the incoming read-miss when the queue is empty.
    always_comb begin
        q_nonempty_s = (count_r != ZERO_CNT);
        have_head_s  = q_nonempty_s || rm_s;
        if (q_nonempty_s) begin
            head_id_s   = q_id_r[rd_ptr_r];
            head_addr_s = q_addr_r[rd_ptr_r];
        end else begin
            head_id_s   = in_id_s;
            head_addr_s = in_addr_s;
        end
    end

    // Return data, forwarding a same-edge write-back to the returned address.
    always_comb begin
        if (wb_s && (in_addr_s == head_addr_s)) begin
            ret_data_s = in_data_s;
        end else begin
            ret_data_s = mem_r[head_addr_s];
        end
    end

    // FSM next-state: head activation, latency countdown and issue decision.
    always_comb begin
        state_nxt_s = state_r;
        lcnt_nxt_s  = lcnt_r;
        activate_s  = 1'b0;
        issue_s     = 1'b0;
        case (state_r)
            ST_IDLE, ST_ISSUE: begin
                if (have_head_s) begin
                    activate_s = 1'b1;
                    lcnt_nxt_s = LCNT_ONE;
                    if (LATENCY == 1) begin
                        issue_s     = 1'b1;
                        state_nxt_s = ST_ISSUE;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (lcnt_r == LAT_M1) begin
                    issue_s     = 1'b1;
                    state_nxt_s = ST_ISSUE;
                end else begin
                    lcnt_nxt_s  = lcnt_r + LCNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                lcnt_nxt_s  = {LCNT_W{1'b0}};
            end
        endcase
    end

    // FSM outputs: queue push/pop/drop and the next return message.
    always_comb begin
        pop_s    = issue_s && q_nonempty_s;
        bypass_s = issue_s && !q_nonempty_s;
        push_s   = rm_s && !bypass_s && ((count_r != FULL_CNT) || pop_s);
        drop_s   = rm_s && (count_r == FULL_CNT) && !pop_s;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
        if (issue_s) begin
            barout_nxt_s = make_return(head_id_s, head_addr_s, ret_data_s);
        end else begin
            barout_nxt_s = {BW{1'b0}};
        end
    end

    // FSM state and latency counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            lcnt_r  <= {LCNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            lcnt_r  <= lcnt_nxt_s;
        end
    end

    // Pending read-miss queue; pointers wrap naturally at QDEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= ZERO_CNT;
            for (int i = 0; i < QDEPTH; i++) begin
                q_id_r[i]   <= {ID_W{1'b0}};
                q_addr_r[i] <= {ADDR_W{1'b0}};
            end
        end else begin
            if (push_s) begin
                q_id_r[wr_ptr_r]   <= in_id_s;
                q_addr_r[wr_ptr_r] <= in_addr_s;
                wr_ptr_r           <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_nxt_s;
        end
    end

    // Memory array: absorbs write-backs, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_N; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wb_s) begin
            mem_r[in_addr_s] <= in_data_s;
        end
    end

    // Registered outputs: bus return, queue-full flag and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            barout <= {BW{1'b0}};
            busy   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            barout <= barout_nxt_s;
            busy   <= (count_nxt_s == FULL_CNT);
            if (drop_s) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule
